out_port_uart: RTL and testbench
================================

Name: out_port_uart

Overview:
- Output-side peripheral for the nic8 CPU.
- Consumes the CPU's OUT-instruction writes (data-bus byte plus one-cycle out strobe) and buffers them in a small FIFO.
- Serialises each byte as an 8N1 UART frame on a single TX line.
- Sits beside the CPU in the system top, wired to the same data bus and out-strobe that load the output register.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2).
- FIFO_DEPTH, 4, byte entries in the FIFO; must be a power of two, ≥2.
- FIFO_AW, 2, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- out_strobe  input  1  CPU OUT write, high for one cycle per byte.
- out_data  input  8  CPU data bus, valid whenever out_strobe is high.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high when a frame is in progress or the FIFO is non-empty.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, any state, including mid-frame):
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO count, read pointer and write pointer = 0.
  - FSM = IDLE; bit counter and baud counter = 0.
  - Any partial frame is abandoned immediately.
- FIFO push:
  - At the posedge where out_strobe=1 and the count at the start of the cycle is below FIFO_DEPTH, write out_data at the write pointer.
  - Write pointer increments, wrapping modulo FIFO_DEPTH.
- Full-FIFO rule:
  - If out_strobe=1 while full=1, the byte is dropped and overflow sets to 1.
  - This holds even if a pop happens in the same cycle.
  - overflow clears only on reset.
- FIFO pop:
  - Happens only in IDLE with count>0.
  - Loads the head byte into the shift register and advances the read pointer (wrap modulo FIFO_DEPTH).
- Simultaneous accepted push and pop: count unchanged.
- FSM states:
  - IDLE:
    - tx=1.
    - If count>0: pop, go to START, clear baud counter.
  - START:
    - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx=shift[0], LSB first; each bit lasts CLKS_PER_BIT cycles, then the register shifts right.
    - After bit index 7 completes, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1; wrapping to 0 ends the current bit.
- Latency:
  - A strobe sampled at edge N makes the byte visible in the FIFO after edge N.
  - If the FSM is IDLE, the pop occurs at edge N+1 and tx falls after edge N+1.
- Back-to-back frames: STOP→IDLE takes one edge, so there is exactly one extra idle-high cycle between frames when the FIFO is non-empty.
- Frame length: 10×CLKS_PER_BIT cycles.
- Output derivation:
  - full = (count==FIFO_DEPTH).
  - busy = (state!=IDLE) || (count!=0).
  - tx, full and busy are registered or derived only from registered state; there is no combinational path from out_strobe.

Optional Feature:
- Macro: OUT_PORT_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11×CLKS_PER_BIT cycles (8E1).
- Undefined:
  - No PARITY state.
  - Frame is 8N1, 10×CLKS_PER_BIT cycles.

Test Plan:
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, no parity unless stated.
- Single byte: strobe out_data=0xA5 at edge 10 → tx falls after edge 11; samples at bit centres read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); busy returns to 0 after 40 cycles of frame.
- Burst: strobe 0x01,0x02,0x03 on consecutive cycles → three frames, each separated by exactly one idle-high cycle; decoded bytes 0x01,0x02,0x03; overflow stays 0.
- Overflow: 6 consecutive strobes 0x10..0x15 while IDLE → 0x10 is popped first; 0x11..0x14 fill the FIFO (full=1); 0x15 is dropped, overflow=1; the serial stream decodes 0x10..0x14 only.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 0xFF → tx=1 immediately (asynchronous), busy=0, full=0; after release, tx stays high with no residual frame.
- Pointer wrap: send 9 bytes 0x20..0x28 spaced 50 cycles apart → all 9 decoded in order; overflow=0.
- Parity build (OUT_PORT_PARITY_EN defined): send 0x07 → parity bit 1, frame 44 cycles; send 0x03 → parity bit 0.

Source files
------------

// File: rtl/out_port_uart.sv
// ---------------------------------------------------------------------------
// out_port_uart
//
// Output-side peripheral for the nic8 CPU. Every OUT write (out_strobe high
// for one cycle with the byte on out_data) is queued in a small FIFO. Queued
// bytes are sent one at a time as UART frames on tx: start bit, 8 data bits
// LSB first, stop bit (8N1).
//
// Build option:
//   OUT_PORT_PARITY_EN - when defined, an even-parity bit is sent between the
//                        data bits and the stop bit (8E1, 11 bit times).
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   FIFO_DEPTH   - FIFO entries, power of two, >= 2
//   FIFO_AW      - log2(FIFO_DEPTH)
//
// Ports:
//   clk        in   system clock, all state changes on posedge
//   reset_n    in   asynchronous active-low reset
//   out_strobe in   CPU OUT write strobe, one cycle per byte
//   out_data   in   CPU data bus byte, valid with out_strobe
//   tx         out  UART serial line, idles high
//   busy       out  frame in progress or FIFO not empty
//   full       out  FIFO holds FIFO_DEPTH entries
//   overflow   out  sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module out_port_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       out_strobe,
  input  logic [7:0] out_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [7:0]         fifoMem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW:0]   count;
  logic [BAUD_W-1:0]  baudCnt;
  logic [BAUD_W-1:0]  baudNext;
  logic [BAUD_W-1:0]  baudInc;
  logic [2:0]         bitIdx;
  logic [2:0]         bitIdxNext;
  logic [7:0]         shiftReg;
  logic [7:0]         shiftNext;
  logic               pushEn;
  logic               popEn;
  logic               bitDone;
`ifdef OUT_PORT_PARITY_EN
  logic               parityBit;
`endif

  // A push is decided on the count at the start of the cycle, so a strobe
  // that meets a full FIFO is dropped even if a pop frees a slot this cycle.
  assign full    = (count == DEPTH_CNT);
  assign pushEn  = out_strobe && !full;
  assign popEn   = (state == IDLE) && (count != '0);
  assign busy    = (state != IDLE) || (count != '0);
  assign bitDone = (baudCnt == BAUD_LAST);
  assign baudInc = bitDone ? '0 : baudCnt + 1'b1;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= out_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popEn) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (pushEn && !popEn) begin
        count <= count + 1'b1;
      end else if (!pushEn && popEn) begin
        count <= count - 1'b1;
      end
      if (out_strobe && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmitter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
    end
  end

`ifdef OUT_PORT_PARITY_EN
  // Parity is taken from the byte as it leaves the FIFO, before shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parityBit <= 1'b0;
    end else if (popEn) begin
      parityBit <= ^fifoMem[rdPtr];
    end
  end
`endif

  // Next-state and line driver. tx depends only on registered state, so
  // there is no combinational path from out_strobe to the serial line.
  always_comb begin
    stateNext  = state;
    baudNext   = baudCnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (popEn) begin
          stateNext = START;
          baudNext  = '0;
          shiftNext = fifoMem[rdPtr];
        end
      end
      START: begin
        tx       = 1'b0;
        baudNext = baudInc;
        if (bitDone) begin
          stateNext  = DATA;
          bitIdxNext = '0;
        end
      end
      DATA: begin
        tx       = shiftReg[0];
        baudNext = baudInc;
        if (bitDone) begin
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
`ifdef OUT_PORT_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end
      end
`ifdef OUT_PORT_PARITY_EN
      PARITY: begin
        tx       = parityBit;
        baudNext = baudInc;
        if (bitDone) begin
          stateNext = STOP;
        end
      end
`endif
      STOP: begin
        tx       = 1'b1;
        baudNext = baudInc;
        if (bitDone) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_out_port_uart.sv
// ---------------------------------------------------------------------------
// tb_out_port_uart
//
// Self-checking bench for out_port_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A reference model tracks the queue of waiting bytes and the position
// inside the current frame in clock cycles; the expected line level is
// derived from that position by plain division. A separate receiver decodes
// bytes from tx at bit centres.
// Define OUT_PORT_PARITY_EN for both files to exercise the parity build.
// ---------------------------------------------------------------------------
module tb_out_port_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OUT_PORT_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       out_strobe = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  logic [7:0] mq[$];
  logic [7:0] mLog[$];
  int         mPos = -1;
  logic [7:0] mCur = 8'h00;
  logic       mOvf = 1'b0;

  logic [7:0] rxQ[$];
  int         startQ[$];
  int         rxPos = -1;
  logic [7:0] rxByte = 8'h00;

  logic lastTx, lastBusy, lastFull, lastOvf;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    logic       par;
  } vec_t;
  vec_t vecs[7];

  out_port_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .out_strobe(out_strobe),
    .out_data(out_data),
    .tx(tx),
    .busy(busy),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no end of test, expected end before 1000000 ns");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edgeCount, act, exp);
    end
  endtask

  function automatic logic modelTx();
    int b;
    if (mPos < 0) return 1'b1;
    b = mPos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return mCur[b-1];
`ifdef OUT_PORT_PARITY_EN
    if (b == 9) return ^mCur;
`endif
    return 1'b1;
  endfunction

  task automatic resetModel();
    mq.delete();
    mPos  = -1;
    mOvf  = 1'b0;
    rxPos = -1;
  endtask

  // One clock cycle: drive inputs, advance model, compare all outputs and
  // feed the bit-centre receiver.
  task automatic applyStimulus(input logic s, input logic [7:0] d);
    int  startSize;
    bit  idleStart;
    int  bitNo;
    out_strobe = s;
    out_data   = d;
    @(posedge clk);
    edgeCount++;
    startSize = mq.size();
    idleStart = (mPos < 0);
    if (!idleStart) begin
      mPos++;
      if (mPos == FRAME_CYC) mPos = -1;
    end
    if (idleStart && startSize > 0) begin
      mCur = mq.pop_front();
      mLog.push_back(mCur);
      mPos = 0;
    end
    if (s) begin
      if (startSize == DEPTH) mOvf = 1'b1;
      else mq.push_back(d);
    end
    #1;
    out_strobe = 1'b0;
    lastTx   = tx;
    lastBusy = busy;
    lastFull = full;
    lastOvf  = overflow;
    checkOutput("tx", 32'(tx), 32'(modelTx()));
    checkOutput("busy", 32'(busy), 32'((mPos >= 0) || (mq.size() != 0)));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    if (rxPos < 0) begin
      if (tx === 1'b0) begin
        rxPos  = 0;
        rxByte = 8'h00;
        startQ.push_back(edgeCount);
      end
    end else begin
      rxPos++;
    end
    if (rxPos >= 0 && (rxPos % CPB) == CPB / 2) begin
      bitNo = rxPos / CPB;
      if (bitNo >= 1 && bitNo <= 8) rxByte[bitNo-1] = tx;
      else if (bitNo == FRAME_BITS - 1) begin
        rxQ.push_back(rxByte);
        rxPos = -1;
      end
    end
  endtask

  initial begin
    int n;
    logic e;

    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[4] = '{8'h80, 10'b1100000000, 1'b1};
    vecs[5] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[6] = '{8'h03, 10'b1000000110, 1'b0};

    $display("[TB] start, frame length %0d cycles", FRAME_CYC);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset tx", 32'(tx), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    resetModel();
    repeat (3) applyStimulus(1'b0, 8'h00);

    // Single frames from the vector table, sampled at bit centres.
    for (int i = 0; i < 7; i++) begin
      rxQ.delete();
      applyStimulus(1'b1, vecs[i].data);
      n = edgeCount;
      checkOutput($sformatf("vec%0d tx high after strobe edge", i), 32'(lastTx), 32'd1);
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("vec%0d tx low after next edge", i), 32'(lastTx), 32'd0);
      for (int k = 0; k < FRAME_BITS; k++) begin
        while (edgeCount < n + 1 + k * CPB + CPB / 2) applyStimulus(1'b0, 8'h00);
`ifdef OUT_PORT_PARITY_EN
        if (k == 9) e = vecs[i].par;
        else if (k == 10) e = 1'b1;
        else e = vecs[i].bits[k];
`else
        e = vecs[i].bits[k];
`endif
        checkOutput($sformatf("vec%0d bit%0d", i, k), 32'(lastTx), 32'(e));
      end
      while (edgeCount < n + FRAME_CYC) applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("vec%0d busy at last frame cycle", i), 32'(lastBusy), 32'd1);
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("vec%0d busy after frame", i), 32'(lastBusy), 32'd0);
      repeat (2) applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("vec%0d rx count", i), 32'(rxQ.size()), 32'd1);
      if (rxQ.size() > 0) checkOutput($sformatf("vec%0d rx byte", i), 32'(rxQ[0]), 32'(vecs[i].data));
    end

    // Burst of three back-to-back strobes.
    rxQ.delete();
    startQ.delete();
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    repeat (3 * (FRAME_CYC + 1) + 5) applyStimulus(1'b0, 8'h00);
    checkOutput("burst rx count", 32'(rxQ.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < rxQ.size()) checkOutput($sformatf("burst byte%0d", k), 32'(rxQ[k]), 32'(k + 1));
    checkOutput("burst start count", 32'(startQ.size()), 32'd3);
    for (int k = 1; k < 3; k++)
      if (k < startQ.size())
        checkOutput($sformatf("burst gap%0d", k), 32'(startQ[k] - startQ[k-1]), 32'(FRAME_CYC + 1));
    checkOutput("burst overflow", 32'(overflow), 32'd0);

    // Nine spaced bytes walk the pointers around the FIFO twice.
    rxQ.delete();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 8'(8'h20 + k));
      repeat (49) applyStimulus(1'b0, 8'h00);
    end
    repeat (FRAME_CYC) applyStimulus(1'b0, 8'h00);
    checkOutput("wrap rx count", 32'(rxQ.size()), 32'd9);
    for (int k = 0; k < 9; k++)
      if (k < rxQ.size()) checkOutput($sformatf("wrap byte%0d", k), 32'(rxQ[k]), 32'(8'h20 + k));
    checkOutput("wrap overflow", 32'(overflow), 32'd0);

    // Six strobes while idle: one popped, four queued, one dropped.
    rxQ.delete();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 8'(8'h10 + k));
      if (k == 4) checkOutput("ovf full after fifth strobe", 32'(lastFull), 32'd1);
      if (k == 4) checkOutput("ovf clear before drop", 32'(lastOvf), 32'd0);
    end
    checkOutput("ovf set after drop", 32'(lastOvf), 32'd1);
    repeat (5 * (FRAME_CYC + 1) + 10) applyStimulus(1'b0, 8'h00);
    checkOutput("ovf rx count", 32'(rxQ.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < rxQ.size()) checkOutput($sformatf("ovf byte%0d", k), 32'(rxQ[k]), 32'(8'h10 + k));
    checkOutput("ovf sticky", 32'(overflow), 32'd1);

    // Random traffic: sparse then dense, checked cycle by cycle.
    rxQ.delete();
    mLog.delete();
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 29) == 0) applyStimulus(1'b1, 8'($urandom));
      else applyStimulus(1'b0, 8'h00);
    end
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b1, 8'($urandom));
      else applyStimulus(1'b0, 8'h00);
    end
    repeat ((DEPTH + 1) * (FRAME_CYC + 1) + 10) applyStimulus(1'b0, 8'h00);
    checkOutput("random rx count", 32'(rxQ.size()), 32'(mLog.size()));
    for (int k = 0; k < mLog.size(); k++)
      if (k < rxQ.size()) checkOutput($sformatf("random byte%0d", k), 32'(rxQ[k]), 32'(mLog[k]));

    // Reset asserted in the middle of data bit 3 of 0xFF with a full FIFO.
    rxQ.delete();
    applyStimulus(1'b1, 8'hFF);
    n = edgeCount;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'h30 + k));
    checkOutput("midreset full before", 32'(lastFull), 32'd1);
    while (edgeCount < n + 18) applyStimulus(1'b0, 8'h00);
    checkOutput("midreset busy before", 32'(lastBusy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset tx", 32'(tx), 32'd1);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset full", 32'(full), 32'd0);
    checkOutput("midreset overflow", 32'(overflow), 32'd0);
    repeat (2) begin
      @(posedge clk);
      edgeCount++;
    end
    #1;
    reset_n = 1'b1;
    resetModel();
    repeat (2 * FRAME_CYC) applyStimulus(1'b0, 8'h00);
    checkOutput("midreset no residual frame", 32'(rxQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
